icache_assoc: RTL and testbench

//   Parametrised read-only instruction cache: 1- or 2-way set-associative, SETS lines/way,
//   128-bit (4-word) lines filled from the 128-bit memory port. Sits between CPU fetch and
//   the instruction memory arbiter. Built-in statistics counters (STAT_EN) replace the

---
 rtl/icache_pkg.sv | 23 ++
 rtl/icache_stat.sv | 36 +++
 rtl/icache_assoc.sv | 191 +++++++++++++++++++
 tb/tb_icache_assoc.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared widths, FSM state type and the saturating-increment helper for the
// set-associative instruction cache.
package icache_pkg;

    localparam int LINE_W     = 128;
    localparam int WORD_W     = 32;
    localparam int OFFSET_W   = 2;
    localparam int ADDR_W     = 30;
    localparam int MEM_ADDR_W = 28;
    localparam int CNT_W      = 32;

    // Controller states: IDLE serves hits, FILL waits for the line from memory.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_t;

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/icache_stat.sv
// Statistics block: three saturating event counters cleared by reset.
module icache_stat
    import icache_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_read,
    input  logic             inc_miss,
    input  logic             inc_stall,
    output logic [CNT_W-1:0] read_count,
    output logic [CNT_W-1:0] read_miss,
    output logic [CNT_W-1:0] read_stalled_cycles
);

    logic [CNT_W-1:0] read_count_q;
    logic [CNT_W-1:0] read_miss_q;
    logic [CNT_W-1:0] read_stalled_q;

    // Count each event once per cycle; values pin at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            read_count_q   <= '0;
            read_miss_q    <= '0;
            read_stalled_q <= '0;
        end else begin
            if (inc_read)  read_count_q   <= sat_inc(read_count_q);
            if (inc_miss)  read_miss_q    <= sat_inc(read_miss_q);
            if (inc_stall) read_stalled_q <= sat_inc(read_stalled_q);
        end
    end

    assign read_count          = read_count_q;
    assign read_miss           = read_miss_q;
    assign read_stalled_cycles = read_stalled_q;

endmodule

// File: rtl/icache_assoc.sv
// Read-only instruction cache, 1- or 2-way set-associative, 4-word lines.
// Handshakes:
//   CPU side: a fetch completes on any cycle with proc_read=1 and proc_stall=0;
//   while stalled the CPU holds proc_addr. Memory side: mem_read is a request
//   held high with a stable mem_addr until the cycle mem_ready=1, which is the
//   single transfer cycle; mem_read drops the cycle after.
// The controller state is held in state_q (type state_t) for observation.
module icache_assoc
    import icache_pkg::*;
#(
    parameter int WAYS    = 2,
    parameter int SETS    = 8,
    parameter int STAT_EN = 1
) (
    input  logic                  clk,
    input  logic                  proc_reset,
    input  logic                  proc_read,
    input  logic [ADDR_W-1:0]     proc_addr,
    output logic [WORD_W-1:0]     proc_rdata,
    output logic                  proc_stall,
    output logic                  mem_read,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    input  logic [LINE_W-1:0]     mem_rdata,
    input  logic                  mem_ready,
    output logic [CNT_W-1:0]      read_count,
    output logic [CNT_W-1:0]      read_miss,
    output logic [CNT_W-1:0]      read_stalled_cycles
);

    localparam int IDX   = $clog2(SETS);
    localparam int TAG_W = ADDR_W - OFFSET_W - IDX;

    // Request address split.
    logic [OFFSET_W-1:0] off;
    logic [IDX-1:0]      idx;
    logic [TAG_W-1:0]    tag;

    assign off = proc_addr[OFFSET_W-1:0];
    assign idx = proc_addr[OFFSET_W +: IDX];
    assign tag = proc_addr[ADDR_W-1 -: TAG_W];

    // Storage arrays (flops). lru_q holds the most-recently-used way per set.
    logic [WAYS-1:0]   valid_q [SETS];
    logic [SETS-1:0]   lru_q;
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [LINE_W-1:0] data_q  [SETS][WAYS];

    // Controller state and latched miss context.
    state_t                  state_q, state_d;
    logic [MEM_ADDR_W-1:0]   line_addr_q;
    logic                    victim_q;

    logic [WAYS-1:0]   way_hit;
    logic              hit;
    logic              hit_way;
    logic              victim_way;
    logic [LINE_W-1:0] hit_line;
    logic              hit_fire;
    logic              miss_start;
    logic              fill_en;
    logic [IDX-1:0]    fill_idx;
    logic [TAG_W-1:0]  fill_tag;

    assign fill_idx = line_addr_q[IDX-1:0];
    assign fill_tag = line_addr_q[MEM_ADDR_W-1:IDX];

    // Tag compare across all ways of the addressed set.
    always_comb begin
        way_hit = '0;
        for (int w = 0; w < WAYS; w++) begin
            way_hit[w] = valid_q[idx][w] && (tag_q[idx][w] == tag);
        end
    end

    assign hit = |way_hit;
    // Way 0 wins if both ways ever matched.
    assign hit_way  = (WAYS == 2) ? ~way_hit[0] : 1'b0;
    assign hit_line = data_q[idx][hit_way];
    assign hit_fire = (state_q == S_IDLE) && proc_read && hit;

    // Victim choice: first invalid way (way 0 first), else the non-MRU way.
    always_comb begin
        victim_way = 1'b0;
        if (WAYS == 2) begin
            if (!valid_q[idx][0]) begin
                victim_way = 1'b0;
            end else if (!valid_q[idx][WAYS-1]) begin
                victim_way = 1'b1;
            end else begin
                victim_way = ~lru_q[idx];
            end
        end
    end

    // Next-state and handshake outputs for the IDLE/FILL controller.
    always_comb begin
        state_d    = state_q;
        proc_stall = 1'b0;
        mem_read   = 1'b0;
        miss_start = 1'b0;
        fill_en    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (proc_read && !hit) begin
                    proc_stall = 1'b1;
                    miss_start = 1'b1;
                    state_d    = S_FILL;
                end
            end
            S_FILL: begin
                proc_stall = 1'b1;
                mem_read   = 1'b1;
                if (mem_ready) begin
                    fill_en = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Hit word is returned combinationally; zero whenever no hit is served.
    always_comb begin
        proc_rdata = '0;
        if (hit_fire) begin
            proc_rdata = hit_line[{off, 5'b0} +: WORD_W];
        end
    end

    assign mem_addr = line_addr_q;

    // State register and capture of the missing line address and victim way.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_q     <= S_IDLE;
            line_addr_q <= '0;
            victim_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (miss_start) begin
                line_addr_q <= proc_addr[ADDR_W-1:OFFSET_W];
                victim_q    <= victim_way;
            end
        end
    end

    // Valid and MRU bookkeeping; reset clears all lines and aborts any fill.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
            end
            lru_q <= '0;
        end else begin
            if (hit_fire) begin
                lru_q[idx] <= hit_way;
            end
            if (fill_en) begin
                valid_q[fill_idx][victim_q] <= 1'b1;
                lru_q[fill_idx]             <= victim_q;
            end
        end
    end

    // Tag and line payload written only by a completing fill.
    always_ff @(posedge clk) begin
        if (fill_en && !proc_reset) begin
            tag_q[fill_idx][victim_q]  <= fill_tag;
            data_q[fill_idx][victim_q] <= mem_rdata;
        end
    end

    // Statistics: completed fetches, miss starts, stalled request cycles.
    if (STAT_EN != 0) begin : g_stat
        icache_stat u_stat (
            .clk                 (clk),
            .rst                 (proc_reset),
            .inc_read            (proc_read & ~proc_stall),
            .inc_miss            (miss_start),
            .inc_stall           (proc_read & proc_stall),
            .read_count          (read_count),
            .read_miss           (read_miss),
            .read_stalled_cycles (read_stalled_cycles)
        );
    end else begin : g_no_stat
        assign read_count          = '0;
        assign read_miss           = '0;
        assign read_stalled_cycles = '0;
    end

endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc: a 2-way/8-set cache with statistics, plus a
// 1-way instance and a 2-way no-statistics instance that share one stimulus.
// Memory returns word k of line L as {2'b10, L, k}, i.e. {2'b10, word_addr}.
module tb_icache_assoc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         proc_reset = 1'b1;
    logic         proc_read  = 1'b0;
    logic [29:0]  proc_addr  = '0;
    logic [31:0]  proc_rdata;
    logic         proc_stall;
    logic         mem_read;
    logic [27:0]  mem_addr;
    logic [127:0] mem_rdata;
    logic         mem_ready  = 1'b0;
    logic [31:0]  read_count, read_miss, read_stalled_cycles;

    logic         w1_read = 1'b0;
    logic [29:0]  w1_addr = '0;
    logic [31:0]  w1_rdata, w1_rc, w1_rm, w1_rs;
    logic         w1_stall, w1_mem_read;
    logic [27:0]  w1_mem_addr;
    logic [127:0] w1_mem_rdata;

    logic [31:0]  z_rdata, z_rc, z_rm, z_rs;
    logic         z_stall, z_mem_read;
    logic [27:0]  z_mem_addr;
    logic [127:0] z_mem_rdata;

    int n_checks = 0;
    int n_pass   = 0;
    int mem_wait = 0;
    int wait_cnt = 0;
    int last_hold;

    function automatic logic [127:0] line_of(input logic [27:0] la);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) begin
            l[32*k +: 32] = {2'b10, la, k[1:0]};
        end
        return l;
    endfunction

    assign mem_rdata    = line_of(mem_addr);
    assign w1_mem_rdata = line_of(w1_mem_addr);
    assign z_mem_rdata  = line_of(z_mem_addr);

    icache_assoc #(.WAYS(2), .SETS(8), .STAT_EN(1)) dut (
        .clk(clk), .proc_reset(proc_reset), .proc_read(proc_read), .proc_addr(proc_addr),
        .proc_rdata(proc_rdata), .proc_stall(proc_stall), .mem_read(mem_read),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .read_count(read_count), .read_miss(read_miss),
        .read_stalled_cycles(read_stalled_cycles)
    );

    icache_assoc #(.WAYS(1), .SETS(8), .STAT_EN(1)) dut_w1 (
        .clk(clk), .proc_reset(proc_reset), .proc_read(w1_read), .proc_addr(w1_addr),
        .proc_rdata(w1_rdata), .proc_stall(w1_stall), .mem_read(w1_mem_read),
        .mem_addr(w1_mem_addr), .mem_rdata(w1_mem_rdata), .mem_ready(w1_mem_read),
        .read_count(w1_rc), .read_miss(w1_rm), .read_stalled_cycles(w1_rs)
    );

    icache_assoc #(.WAYS(2), .SETS(8), .STAT_EN(0)) dut_ns (
        .clk(clk), .proc_reset(proc_reset), .proc_read(w1_read), .proc_addr(w1_addr),
        .proc_rdata(z_rdata), .proc_stall(z_stall), .mem_read(z_mem_read),
        .mem_addr(z_mem_addr), .mem_rdata(z_mem_rdata), .mem_ready(z_mem_read),
        .read_count(z_rc), .read_miss(z_rm), .read_stalled_cycles(z_rs)
    );

    // Memory responder for the main instance: ready after mem_wait request cycles.
    always @(negedge clk) begin
        if (proc_reset || mem_ready) begin
            mem_ready = 1'b0;
            wait_cnt  = 0;
        end else if (mem_read) begin
            if (wait_cnt >= mem_wait) mem_ready = 1'b1;
            else wait_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Issue one fetch at a falling edge and hold it until served (bounded).
    task automatic fetch(input string tag, input logic [29:0] a, input int exp_cyc);
        int cyc;
        int hold;
        bit seen;
        proc_read = 1'b1;
        proc_addr = a;
        cyc  = 0;
        hold = 0;
        seen = 1'b0;
        #1;
        while (proc_stall && cyc < 40) begin
            if (mem_read && !seen) begin
                check({tag, ":mem_addr"}, {4'b0, mem_addr}, {4'b0, a[29:2]});
                seen = 1'b1;
            end
            if (mem_read && !mem_ready) hold++;
            @(negedge clk);
            #1;
            cyc++;
        end
        check({tag, ":stall_cycles"}, cyc, exp_cyc);
        check({tag, ":rdata"}, proc_rdata, {2'b10, a});
        check({tag, ":mem_read_low"}, {31'b0, mem_read}, 32'd0);
        last_hold = hold;
        @(negedge clk);
        proc_read = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] st0;
        logic [29:0] a;
        int cyc;

        // Clock/reset
        repeat (2) @(negedge clk);
        proc_reset = 1'b0;
        #1;
        check("rst:mem_read", {31'b0, mem_read}, 32'd0);
        check("rst:stall_idle", {31'b0, proc_stall}, 32'd0);
        check("rst:rdata", proc_rdata, 32'd0);
        check("rst:read_count", read_count, 32'd0);
        check("rst:read_miss", read_miss, 32'd0);
        check("rst:stalled", read_stalled_cycles, 32'd0);
        proc_read = 1'b1;
        #1;
        check("rst:stall_on_read", {31'b0, proc_stall}, 32'd1);

        // Test 1: cold miss then hits on the rest of the line.
        fetch("t1_000", 30'h000, 2);
        check("t1:read_miss", read_miss, 32'd1);
        fetch("t1_001", 30'h001, 0);
        fetch("t1_002", 30'h002, 0);
        fetch("t1_003", 30'h003, 0);
        check("t1:read_count", read_count, 32'd4);
        check("t1:stalled", read_stalled_cycles, 32'd2);

        // Test 2: two lines share set 0, then LRU eviction.
        fetch("t2_020", 30'h020, 2);
        fetch("t2_000h", 30'h000, 0);
        fetch("t2_020h", 30'h020, 0);
        fetch("t2_000t", 30'h000, 0);
        fetch("t2_040", 30'h040, 2);
        fetch("t2_000k", 30'h000, 0);
        fetch("t2_020m", 30'h020, 2);
        fetch("t2_000f", 30'h000, 0);
        check("t2:read_miss", read_miss, 32'd4);

        // Test 4: slow memory, five request cycles before ready.
        st0 = read_stalled_cycles;
        mem_wait = 5;
        fetch("t4_100", 30'h100, 7);
        check("t4:hold_cycles", last_hold, 32'd5);
        check("t4:stalled_delta", read_stalled_cycles - st0, 32'd7);
        mem_wait = 0;

        // Test 5: reset in the middle of a fill.
        mem_wait = 10;
        proc_read = 1'b1;
        proc_addr = 30'h200;
        @(negedge clk);
        #1;
        check("t5:in_fill", {31'b0, mem_read}, 32'd1);
        @(negedge clk);
        proc_reset = 1'b1;
        @(negedge clk);
        #1;
        check("t5:mem_read_abort", {31'b0, mem_read}, 32'd0);
        check("t5:stall_after_rst", {31'b0, proc_stall}, 32'd1);
        check("t5:read_count_clr", read_count, 32'd0);
        check("t5:read_miss_clr", read_miss, 32'd0);
        check("t5:stalled_clr", read_stalled_cycles, 32'd0);
        proc_reset = 1'b0;
        mem_wait = 0;
        fetch("t5_200", 30'h200, 2);
        check("t5:read_miss", read_miss, 32'd1);
        check("t5:read_count", read_count, 32'd1);

        // Test 6: saturation of the completed-fetch counter.
        dut.g_stat.u_stat.read_count_q = 32'hFFFF_FFFE;
        fetch("t6_h1", 30'h200, 0);
        check("t6:sat1", read_count, 32'hFFFF_FFFF);
        fetch("t6_h2", 30'h200, 0);
        check("t6:sat2", read_count, 32'hFFFF_FFFF);

        // Test 3: direct-mapped conflict; shared stimulus also drives the
        // no-statistics instance.
        for (int i = 0; i < 4; i++) begin
            a = (i % 2 == 1) ? 30'h020 : 30'h000;
            w1_read = 1'b1;
            w1_addr = a;
            cyc = 0;
            #1;
            while (w1_stall && cyc < 40) begin
                @(negedge clk);
                #1;
                cyc++;
            end
            check("t3:cycles", cyc, 32'd2);
            check("t3:rdata", w1_rdata, {2'b10, a});
            check("t3:ns_rdata", z_rdata, {2'b10, a});
            @(negedge clk);
            w1_read = 1'b0;
        end
        check("t3:read_miss", w1_rm, 32'd4);
        check("t3:read_count", w1_rc, 32'd4);
        check("t3:stalled", w1_rs, 32'd8);
        check("ns:read_count", z_rc, 32'd0);
        check("ns:read_miss", z_rm, 32'd0);
        check("ns:stalled", z_rs, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
